mio_bus_bridge: RTL and testbench

Memory-mapped I/O bridge directly downstream of the pipelined RISC-V core's MEM stage. It consumes the core's data-side bus outputs: address, store data, write strobe and byte enables. It returns load data on the core's `Datain` and drives `MIO_ready` and `INT` back into the core. It decodes the address into a multi-cycle data RAM and three single-cycle peripherals: LEDs/switches, 7-segment display register, and a down-counter timer.

---
 rtl/mio_bus_bridge.sv | 122 ++++++++++++
 tb/tb_mio_bus_bridge.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_bridge.sv
// mio_bus_bridge: MMIO bridge from the core's MEM stage to data RAM, LED/SW, 7-seg and timer.
// Timer registers (CNT/IRQ) and int_out are built only when MIO_TIMER_EN is defined.
module mio_bus_bridge #(
    parameter int RAM_AW  = 14,
    parameter int RAM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              cpu_mem_w,
    input  logic              cpu_mem_r,
    input  logic [3:0]        cpu_wea,
    output logic [31:0]       cpu_rdata,
    output logic              mio_ready,
    output logic              int_out,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic [15:0]       sw,
    output logic [15:0]       led,
    output logic [31:0]       seg_data
);
    typedef enum logic [1:0] {IDLE, RAM_WAIT, RESP} state_t;

    state_t            state_q;
    logic [2:0]        wait_q;
    logic [RAM_AW-1:0] raddr_q;
    logic [31:0]       rdata_q;
    logic              ready_q;
    logic [15:0]       led_q;
    logic [31:0]       seg_q;
    logic              wr, rd, hit_ram, hit_seg, hit_led;
    logic [31:0]       tmr_rd, per_rd;

    // A simultaneous read+write request is a write.
    assign wr      = state_q == IDLE && cpu_mem_w;
    assign rd      = state_q == IDLE && cpu_mem_r && !cpu_mem_w;
    assign hit_ram = cpu_addr[31:16] == 16'h0;
    assign hit_seg = cpu_addr == 32'hE000_0000;
    assign hit_led = cpu_addr == 32'hF000_0000;
    assign per_rd  = hit_led ? {led_q, sw} : hit_seg ? seg_q : tmr_rd;

    assign ram_en    = ((wr || rd) && hit_ram) || state_q == RAM_WAIT;
    assign ram_we    = wr && hit_ram ? cpu_wea : 4'b0;
    assign ram_addr  = state_q == IDLE ? cpu_addr[RAM_AW+1:2] : raddr_q;
    assign ram_wdata = cpu_wdata;
    assign cpu_rdata = rdata_q;
    assign mio_ready = ready_q;
    assign led       = led_q;
    assign seg_data  = seg_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= 3'd0;
            raddr_q <= '0;
            rdata_q <= 32'h0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (rd && hit_ram) begin
                    state_q <= RAM_WAIT;
                    wait_q  <= 3'd1;
                    raddr_q <= cpu_addr[RAM_AW+1:2];
                    ready_q <= 1'b0;
                end else if (rd) rdata_q <= per_rd;
                RAM_WAIT: if (wait_q == 3'(RAM_LAT)) begin
                    state_q <= RESP;
                    rdata_q <= ram_rdata;
                    ready_q <= 1'b1;
                end else wait_q <= wait_q + 3'd1;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= 16'h0;
            seg_q <= 32'h0;
        end else if (wr) begin
            for (int i = 0; i < 2; i++) if (hit_led && cpu_wea[i]) led_q[8*i +: 8] <= cpu_wdata[8*i +: 8];
            for (int i = 0; i < 4; i++) if (hit_seg && cpu_wea[i]) seg_q[8*i +: 8] <= cpu_wdata[8*i +: 8];
        end
    end

`ifdef MIO_TIMER_EN
    logic [CNT_W-1:0] cnt_q, reload_q;
    logic             int_q, cnt_wr, irq_wr, expire;

    assign cnt_wr  = wr && cpu_addr == 32'hF000_0004;
    assign irq_wr  = wr && cpu_addr == 32'hF000_0008;
    // A load in the same cycle pre-empts the 1->0 step.
    assign expire  = !cnt_wr && cnt_q == CNT_W'(1);
    assign tmr_rd  = cpu_addr == 32'hF000_0004 ? 32'(cnt_q) :
                     cpu_addr == 32'hF000_0008 ? {31'b0, int_q} : 32'h0;
    assign int_out = int_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            reload_q <= '0;
            int_q    <= 1'b0;
        end else begin
            if (cnt_wr) begin
                cnt_q    <= cpu_wdata[CNT_W-1:0];
                reload_q <= cpu_wdata[CNT_W-1:0];
            end else if (expire) cnt_q <= reload_q;
            else if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            if (expire) int_q <= 1'b1;
            else if (irq_wr) int_q <= 1'b0;
        end
    end
`else
    assign tmr_rd  = 32'h0;
    assign int_out = 1'b0;
`endif
endmodule

// File: tb/tb_mio_bus_bridge.sv
// tb_mio_bus_bridge: directed bench with a transaction-level reference model and per-cycle compare.
module tb_mio_bus_bridge;
    localparam int AW  = 14;
    localparam int LAT = 2;
`ifdef MIO_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    logic          clk = 1'b0, reset = 1'b1;
    logic [31:0]   cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic          cpu_mem_w = 1'b0, cpu_mem_r = 1'b0;
    logic [3:0]    cpu_wea = 4'h0;
    logic [15:0]   sw = 16'h0;
    logic [31:0]   cpu_rdata, ram_wdata, ram_rdata, seg_data;
    logic          mio_ready, int_out, ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   led;

    always #5 clk = ~clk;

    mio_bus_bridge #(.RAM_AW(AW), .RAM_LAT(LAT), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_mem_w(cpu_mem_w), .cpu_mem_r(cpu_mem_r), .cpu_wea(cpu_wea),
        .cpu_rdata(cpu_rdata), .mio_ready(mio_ready), .int_out(int_out),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .sw(sw), .led(led), .seg_data(seg_data)
    );

    // Bench RAM: byte-writable, read data appears LAT cycles after ram_en.
    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] pipe [LAT];
    assign ram_rdata = pipe[LAT-1];

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    initial for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);

    always @(posedge clk) begin
        if (ram_en) for (int b = 0; b < 4; b++) if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        pipe[0] <= ram[ram_addr];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state.
    logic [31:0]   shadow [int];
    logic [15:0]   e_led = 16'h0;
    logic [31:0]   e_seg = 32'h0, e_rdata = 32'h0;
    logic          e_ready = 1'b1, e_rd_v = 1'b1, e_ram_en = 1'b0;
    logic [3:0]    e_ram_we = 4'h0;
    logic [AW-1:0] e_raddr = '0;
    int            cw = 0, cv = 0, exp_seen = -1, clr_vis = -1;
    bit            chk_on = 1'b0;
    int            total = 0, bad = 0;

    function automatic logic [31:0] shadow_rd(int i);
        return shadow.exists(i) ? shadow[i] : init_word(i);
    endfunction

    // Count after a load of cv in cycle cw: cv, cv-1, ..., 1, cv, ...
    function automatic logic [31:0] cnt_at(int t);
        if (!TIMER || cv == 0) return 32'h0;
        return 32'(cv - ((t - cw - 1) % cv));
    endfunction

    // Interrupt becomes visible at cycles cw+1+k*cv (k>=1).
    function automatic void note_exp(int t);
        int le;
        if (TIMER && cv != 0 && t >= cw + cv + 1) begin
            le = cw + 1 + cv * ((t - cw - 1) / cv);
            if (le > exp_seen) exp_seen = le;
        end
    endfunction

    function automatic bit int_at(int t);
        note_exp(t);
        return TIMER && exp_seen >= 0 && exp_seen >= clr_vis;
    endfunction

    function automatic logic [31:0] model_read(logic [31:0] a, int t);
        if (a[31:16] == 16'h0) return shadow_rd(int'(a[AW+1:2]));
        if (a == 32'hE000_0000) return e_seg;
        if (a == 32'hF000_0000) return {e_led, sw};
        if (a == 32'hF000_0004) return cnt_at(t);
        if (a == 32'hF000_0008) return {31'b0, int_at(t)};
        return 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (chk_on && !reset) begin
        check("mio_ready", 32'(mio_ready), 32'(e_ready));
        check("led", 32'(led), 32'(e_led));
        check("seg_data", seg_data, e_seg);
        check("int_out", 32'(int_out), 32'(int_at(cyc)));
        check("ram_en", 32'(ram_en), 32'(e_ram_en));
        check("ram_we", 32'(ram_we), 32'(e_ram_we));
        if (e_ram_en) check("ram_addr", 32'(ram_addr), 32'(e_raddr));
        if (e_rd_v) check("cpu_rdata", cpu_rdata, e_rdata);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        cpu_mem_r = r;
        cpu_mem_w = w;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wea   = we;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input bit also_r);
        int t0;
        logic [31:0] v;
        t0 = cyc;
        drive(also_r, 1'b1, a, d, we);
        e_ram_en = a[31:16] == 16'h0;
        e_ram_we = e_ram_en ? we : 4'h0;
        e_raddr  = a[AW+1:2];
        tick;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        e_ram_en = 1'b0;
        e_ram_we = 4'h0;
        if (a[31:16] == 16'h0) begin
            v = shadow_rd(int'(a[AW+1:2]));
            for (int b = 0; b < 4; b++) if (we[b]) v[8*b +: 8] = d[8*b +: 8];
            shadow[int'(a[AW+1:2])] = v;
        end else if (a == 32'hF000_0000) begin
            for (int b = 0; b < 2; b++) if (we[b]) e_led[8*b +: 8] = d[8*b +: 8];
        end else if (a == 32'hE000_0000) begin
            for (int b = 0; b < 4; b++) if (we[b]) e_seg[8*b +: 8] = d[8*b +: 8];
        end else if (TIMER && a == 32'hF000_0004) begin
            note_exp(t0);
            cw = t0;
            cv = int'(d);
        end else if (TIMER && a == 32'hF000_0008) clr_vis = t0 + 1;
    endtask

    task automatic do_rd(input logic [31:0] a, output logic [31:0] got);
        logic [31:0] exp;
        exp = model_read(a, cyc);
        drive(1'b1, 1'b0, a, 32'h0, 4'h0);
        if (a[31:16] == 16'h0) begin
            e_ram_en = 1'b1;
            e_ram_we = 4'h0;
            e_raddr  = a[AW+1:2];
            tick;
            e_ready = 1'b0;
            e_rd_v  = 1'b0;
            repeat (LAT) tick;
            drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            e_ready  = 1'b1;
            e_ram_en = 1'b0;
            e_rdata  = exp;
            e_rd_v   = 1'b1;
            got = cpu_rdata;
            tick;
        end else begin
            e_ram_en = 1'b0;
            e_ram_we = 4'h0;
            tick;
            drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            e_rdata = exp;
            e_rd_v  = 1'b1;
            got = cpu_rdata;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        repeat (3) tick;
        reset = 1'b0;
        check("rst_ready", 32'(mio_ready), 32'h1);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_int", 32'(int_out), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_seg", seg_data, 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        chk_on = 1'b1;

        sw = 16'h00A5;
        do_rd(32'hF000_0000, got);
        check("sw_read", got, 32'h0000_00A5);

        do_wr(32'h0000_0010, 32'h1234_5678, 4'b0011, 1'b0);
        do_rd(32'h0000_0010, got);
        check("ram_merge", got, 32'hC0DE_5678);
        do_rd(32'h0000_0100, got);
        check("ram_plain", got, 32'hC0DE_0040);
        do_wr(32'h0000_0100, 32'hA1B2_C3D4, 4'b1111, 1'b0);
        do_rd(32'h0000_0100, got);
        check("ram_full", got, 32'hA1B2_C3D4);

        do_wr(32'hE000_0000, 32'hDEAD_BEEF, 4'b1000, 1'b0);
        do_rd(32'hE000_0000, got);
        check("seg_lane3", got, 32'hDE00_0000);
        check("seg_out", seg_data, 32'hDE00_0000);

        do_wr(32'hF000_0000, 32'h0000_BEEF, 4'b1111, 1'b1);
        check("rw_no_read", cpu_rdata, 32'hDE00_0000);
        sw = 16'h1234;
        do_rd(32'hF000_0000, got);
        check("led_raw", got, 32'hBEEF_1234);

        do_wr(32'hF000_0004, 32'd3, 4'h0, 1'b0);
        do_rd(32'hF000_0004, got);
        check("cnt_3", got, TIMER ? 32'd3 : 32'd0);
        do_rd(32'hF000_0004, got);
        check("cnt_2", got, TIMER ? 32'd2 : 32'd0);
        do_wr(32'hF000_0008, 32'h0, 4'h0, 1'b0);
        check("int_set_wins", 32'(int_out), TIMER ? 32'd1 : 32'd0);
        do_rd(32'hF000_0004, got);
        check("cnt_reload", got, TIMER ? 32'd3 : 32'd0);
        do_rd(32'hF000_0008, got);
        check("irq_read", got, TIMER ? 32'd1 : 32'd0);
        tick;
        do_wr(32'hF000_0008, 32'hFFFF_FFFF, 4'h0, 1'b0);
        check("int_clear", 32'(int_out), 32'd0);
        do_wr(32'hF000_0004, 32'd0, 4'hF, 1'b0);
        repeat (3) tick;

        sw = 16'h00A5;
        do_rd(32'hF000_0000, got);
        check("led_sw", got, 32'hBEEF_00A5);
        do_wr(32'h8000_0000, 32'hFFFF_FFFF, 4'hF, 1'b1);
        check("unmapped_rw", cpu_rdata, 32'hBEEF_00A5);
        do_rd(32'h8000_0000, got);
        check("unmapped_rd", got, 32'h0);

        do_rd(32'hE000_0000, got);
        drive(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        e_ram_en = 1'b1;
        e_raddr  = 14'h80;
        tick;
        e_ready = 1'b0;
        e_rd_v  = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick;
        reset = 1'b0;
        e_ready  = 1'b1;
        e_ram_en = 1'b0;
        e_rdata  = 32'h0;
        e_rd_v   = 1'b1;
        e_led    = 16'h0;
        e_seg    = 32'h0;
        cw = cyc;
        cv = 0;
        exp_seen = -1;
        clr_vis  = -1;
        check("rstmid_ready", 32'(mio_ready), 32'h1);
        check("rstmid_ram_en", 32'(ram_en), 32'h0);
        check("rstmid_rdata", cpu_rdata, 32'h0);
        check("rstmid_led", 32'(led), 32'h0);
        do_rd(32'h0000_0010, got);
        check("ram_after_rst", got, 32'hC0DE_5678);
        repeat (3) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
